// File: rtl/sc_statemachine_rows.sv
// sc_statemachine_rows
//   Registered game-flow controller for the road display. Four states
//   (IDLE, LOAD, PLAY, GAMEOVER) drive one MUX41 select code per row and a
//   one-cycle SHIFT pulse that advances the road during play.
//
// Parameters
//   MUX41_SELECTWIDTH  width of each row select code (>= 2)
//   NUM_ROWS           number of rows driven (1..16)
//
// Ports
//   SC_STATEMACHINEROWS_CLOCK_50          system clock, rising edge
//   SC_STATEMACHINEROWS_RESET_InHigh      synchronous reset, active high
//   SC_STATEMACHINEROWS_START_InLow       start button, active-low level
//   SC_STATEMACHINEROWS_COLLISION_InHigh  collision level
//   SC_STATEMACHINEROWS_TICK_InHigh       one-cycle game tick
//   SC_STATEMACHINEROWS_SELECT_OUT        row selects, row r at [r*W +: W]
//   SC_STATEMACHINEROWS_SHIFT_OutHigh     one-cycle road-advance pulse
//   SC_STATEMACHINEROWS_STATE_OUT         current state code
//
// Optional build macro
//   SC_STATEMACHINEROWS_BLINK_EN  GAMEOVER rows blink FULL/CLEAR on each tick
//                                 (constant FULL when undefined)

module sc_statemachine_rows #(
  parameter int MUX41_SELECTWIDTH = 2,
  parameter int NUM_ROWS          = 8
) (
  input  logic                                  SC_STATEMACHINEROWS_CLOCK_50,
  input  logic                                  SC_STATEMACHINEROWS_RESET_InHigh,
  input  logic                                  SC_STATEMACHINEROWS_START_InLow,
  input  logic                                  SC_STATEMACHINEROWS_COLLISION_InHigh,
  input  logic                                  SC_STATEMACHINEROWS_TICK_InHigh,
  output logic [NUM_ROWS*MUX41_SELECTWIDTH-1:0] SC_STATEMACHINEROWS_SELECT_OUT,
  output logic                                  SC_STATEMACHINEROWS_SHIFT_OutHigh,
  output logic [1:0]                            SC_STATEMACHINEROWS_STATE_OUT
);

  localparam int W  = MUX41_SELECTWIDTH;
  localparam int FW = $clog2(NUM_ROWS + 1);

  localparam logic [W-1:0] SEL_CLEAR  = W'(0);
  localparam logic [W-1:0] SEL_FULL   = W'(1);
  localparam logic [W-1:0] SEL_RANDOM = W'(2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD     = 2'd1,
    PLAY     = 2'd2,
    GAMEOVER = 2'd3
  } state_t;

  state_t        state_q;
  logic [FW-1:0] fill_q;
  logic          start_prev_q;
  logic          shift_q;
  logic          start_ev;
  logic          go_full;

  // Falling edge of the active-low button; previous level resets high so a
  // button held through reset does not fire.
  assign start_ev = start_prev_q & ~SC_STATEMACHINEROWS_START_InLow;

`ifdef SC_STATEMACHINEROWS_BLINK_EN
  logic blink_q;
  assign go_full = ~blink_q;
`else
  assign go_full = 1'b1;
`endif

  always_ff @(posedge SC_STATEMACHINEROWS_CLOCK_50) begin
    if (SC_STATEMACHINEROWS_RESET_InHigh) begin
      state_q      <= IDLE;
      fill_q       <= '0;
      start_prev_q <= 1'b1;
      shift_q      <= 1'b0;
`ifdef SC_STATEMACHINEROWS_BLINK_EN
      blink_q      <= 1'b0;
`endif
    end else begin
      start_prev_q <= SC_STATEMACHINEROWS_START_InLow;
      shift_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          fill_q <= '0;
          if (start_ev) state_q <= LOAD;
        end
        LOAD: begin
          if (SC_STATEMACHINEROWS_TICK_InHigh) begin
            fill_q <= fill_q + FW'(1);
            // Last reveal tick: fill lands on NUM_ROWS and stays there.
            if (fill_q == FW'(NUM_ROWS - 1)) state_q <= PLAY;
          end
        end
        PLAY: begin
          // Collision beats a same-cycle tick: no shift on the way out.
          if (SC_STATEMACHINEROWS_COLLISION_InHigh) begin
            state_q <= GAMEOVER;
`ifdef SC_STATEMACHINEROWS_BLINK_EN
            blink_q <= 1'b0;
`endif
          end else if (SC_STATEMACHINEROWS_TICK_InHigh) begin
            shift_q <= 1'b1;
          end
        end
        GAMEOVER: begin
          if (start_ev) begin
            state_q <= IDLE;
            fill_q  <= '0;
          end
`ifdef SC_STATEMACHINEROWS_BLINK_EN
          if (SC_STATEMACHINEROWS_TICK_InHigh) blink_q <= ~blink_q;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Per-row select decode from registered state only.
  for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
    logic [W-1:0] code;
    always_comb begin
      code = SEL_CLEAR;
      case (state_q)
        IDLE:     code = SEL_CLEAR;
        LOAD:     code = (fill_q > FW'(r)) ? SEL_RANDOM : SEL_CLEAR;
        PLAY:     code = SEL_RANDOM;
        GAMEOVER: code = go_full ? SEL_FULL : SEL_CLEAR;
        default:  code = SEL_CLEAR;
      endcase
    end
    assign SC_STATEMACHINEROWS_SELECT_OUT[r*W +: W] = code;
  end

  assign SC_STATEMACHINEROWS_SHIFT_OutHigh = shift_q;
  assign SC_STATEMACHINEROWS_STATE_OUT     = state_q;

endmodule

// File: doc/sc_statemachine_rows.md
# sc_statemachine_rows

Sequential game-flow controller for the road display. It replaces the fixed, combinational select generator with a registered four-state machine. It drives one multiplexer select code per display row, for a parametrised number of rows and select width. It sits between the start/collision/tick sources and the per-row MUX41 bank, and emits a shift pulse that advances the road pattern during play.

## Interface
- MUX41_SELECTWIDTH, 2: width of each row's select code (≥2).
- NUM_ROWS, 8: number of display rows driven (1..16).
- SC_STATEMACHINEROWS_CLOCK_50  in  1  system clock; all logic on rising edge.
- SC_STATEMACHINEROWS_RESET_InHigh  in  1  reset, synchronous, active-high.
- SC_STATEMACHINEROWS_START_InLow  in  1  start button, already debounced and synchronous, active-low level.
- SC_STATEMACHINEROWS_COLLISION_InHigh  in  1  collision flag from the car/obstacle comparator, level.
- SC_STATEMACHINEROWS_TICK_InHigh  in  1  one-cycle pulse from the game prescaler.
- SC_STATEMACHINEROWS_SELECT_OUT  out  NUM_ROWS*MUX41_SELECTWIDTH  flattened row selects; row r occupies bits [r*W+W-1 : r*W].
- SC_STATEMACHINEROWS_SHIFT_OutHigh  out  1  one-cycle road-advance pulse.
- SC_STATEMACHINEROWS_STATE_OUT  out  2  current state code.

## Operation
- Select codes: CLEAR=0, FULL=1, RANDOM=2. Values are zero-extended to MUX41_SELECTWIDTH.
- States and codes: IDLE=0, LOAD=1, PLAY=2, GAMEOVER=3.
- Start event (start_ev) is a falling edge on START_InLow. It is detected against a registered copy of the previous level, and that copy resets to 1. A held-low button yields exactly one event.
- IDLE:
  - All rows CLEAR; fill counter = 0.
  - start_ev → LOAD.
- LOAD: progressive reveal.
  - Fill counter is $clog2(NUM_ROWS+1) bits wide. Each TICK increments it.
  - Row r shows RANDOM if r < fill, otherwise CLEAR.
  - On the TICK that takes fill to NUM_ROWS → PLAY. Fill then holds at NUM_ROWS and never wraps.
- PLAY:
  - All rows RANDOM.
  - Each TICK produces SHIFT_OutHigh=1 for one cycle.
  - COLLISION=1 → GAMEOVER.
- GAMEOVER:
  - All rows FULL; SHIFT is never asserted.
  - start_ev → IDLE. Fill clears to 0 on entry to IDLE.
- Ignored inputs:
  - start_ev in LOAD or PLAY.
  - COLLISION outside PLAY.
  - TICK in IDLE or GAMEOVER, except for blink (see Configuration).
- Simultaneous events:
  - COLLISION and TICK in the same PLAY cycle: collision wins; no SHIFT pulse.
  - Reset together with any event: reset wins.
- Reset mid-operation, from any state: next cycle is IDLE with fill=0, blink phase=0, all outputs at reset value.

## Timing
- State, fill counter, blink phase, previous-start level and SHIFT are registers.
- SELECT_OUT and STATE_OUT are decoded combinationally from registered state, fill and blink phase.
- Latency: an event sampled at edge k is visible on SELECT_OUT, STATE_OUT and SHIFT after edge k, i.e. one cycle.
- SHIFT is high exactly one cycle per qualifying TICK. Back-to-back TICKs give back-to-back pulses.
- Reset values:
  - SELECT_OUT all zero (CLEAR).
  - SHIFT_OutHigh = 0.
  - STATE_OUT = 0.
- LOAD duration is exactly NUM_ROWS TICKs. PLAY is first visible in the cycle after the NUM_ROWS-th TICK.

## Configuration
- SC_STATEMACHINEROWS_BLINK_EN:
  - Defined: GAMEOVER keeps a 1-bit blink phase that toggles on each TICK. Rows show FULL when phase=0 and CLEAR when phase=1. Phase clears to 0 on GAMEOVER entry and on reset.
  - Undefined: the blink register is not built; GAMEOVER rows are constant FULL.

## Test plan
- Reset: hold RESET 2 cycles with NUM_ROWS=8, W=2 → SELECT_OUT=16'h0000, STATE=0, SHIFT=0.
- Fill: start_ev, then 8 TICKs spaced 3 cycles apart.
  - After TICK 1, SELECT_OUT=16'h0002; after TICK 3, 16'h002A.
  - After TICK 8, SELECT_OUT=16'hAAAA and STATE=2.
  - A start_ev injected during LOAD is ignored.
- Play/shift: in PLAY, 5 TICKs (two of them adjacent) → exactly 5 SHIFT pulses, each 1 cycle; a held-low START produces no state change.
- Collision priority: in PLAY, COLLISION and TICK on the same cycle → no SHIFT, STATE=3, SELECT_OUT=16'h5555. With BLINK_EN, the next TICK gives 16'h0000 and the one after gives 16'h5555.
- Restart and mid-reset:
  - In GAMEOVER, start_ev → STATE=0, SELECT_OUT=0. A second start_ev → LOAD with fill restarting at 0.
  - RESET asserted at fill=4 → IDLE next cycle, SELECT_OUT=0.
